// File: rtl/acumulador_soma_pkg.sv
// Shared definitions for the acumulador_soma block: FSM state encodings and
// default sizing of the accumulator.
package acumulador_soma_pkg;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ACUMULANDO = 2'd1,
        PRONTO     = 2'd2
    } estado_t;

    localparam int ACC_W_PADRAO      = 12;
    localparam int N_AMOSTRAS_PADRAO = 4;

endpackage

// File: rtl/acumulador_soma_somador_sat.sv
// Combinational saturating adder: one extra bit of headroom decides overflow,
// and an overflowing result is clamped to all ones.
module somador_sat #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_soma,
    output logic         o_estouro
);

    logic [W:0] w_ext;

    assign w_ext     = {1'b0, i_a} + {1'b0, i_b};
    assign o_estouro = w_ext[W];
    assign o_soma    = w_ext[W] ? {W{1'b1}} : w_ext[W-1:0];

endmodule

// File: rtl/somador8.sv
// Combinational 8-bit adder that feeds the accumulator; the carry is the 9th bit.
module somador8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [8:0] S
);

    assign S = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/acumulador_soma.sv
// Accumulates N_AMOSTRAS handshaked adder sums into a saturating register and
// presents the total downstream through a valid/ready handshake.
module acumulador_soma
    import acumulador_soma_pkg::*;
#(
    parameter int N_AMOSTRAS = N_AMOSTRAS_PADRAO,
    parameter int ACC_W      = ACC_W_PADRAO
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                iniciar,
    input  logic [8:0]                          S_in,
    input  logic                                valid_in,
    output logic                                ready_out,
    output logic [ACC_W-1:0]                    total,
    output logic                                total_valid,
    input  logic                                total_ready,
    output logic                                saturou,
    output logic [$clog2(N_AMOSTRAS+1)-1:0]     contagem
);

    localparam int               CNT_W  = $clog2(N_AMOSTRAS + 1);
    localparam logic [CNT_W-1:0] ULTIMA = CNT_W'(N_AMOSTRAS - 1);

    estado_t            r_estado;
    estado_t            w_estado_prox;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic [ACC_W-1:0]   w_parcela;
    logic [ACC_W-1:0]   w_soma;
    logic               w_estouro;
    logic               w_aceita;
    logic               w_inicia;

    assign w_parcela = ACC_W'(S_in);
    assign w_aceita  = valid_in && (r_estado == ACUMULANDO);
    assign w_inicia  = iniciar && (r_estado == OCIOSO);

    somador_sat #(
        .W (ACC_W)
    ) u_somador_sat (
        .i_a       (r_acc),
        .i_b       (w_parcela),
        .o_soma    (w_soma),
        .o_estouro (w_estouro)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Handshake outputs depend on registered state only, never on inputs.
    always_comb begin
        w_estado_prox = r_estado;
        ready_out     = 1'b0;
        total_valid   = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                if (iniciar) w_estado_prox = ACUMULANDO;
            end
            ACUMULANDO: begin
                ready_out = 1'b1;
                if (w_aceita && (r_cnt == ULTIMA)) w_estado_prox = PRONTO;
            end
            PRONTO: begin
                total_valid = 1'b1;
                if (total_ready) w_estado_prox = OCIOSO;
            end
            default: w_estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_inicia) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_aceita) begin
            r_acc <= w_soma;
            r_cnt <= r_cnt + 1'b1;
            r_sat <= r_sat | w_estouro;
        end
    end

    assign total    = r_acc;
    assign contagem = r_cnt;
    assign saturou  = r_sat;

endmodule
